// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM stage of the pipelined MIPS core.
package mips_pkg;

    localparam int         DW         = 32;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-state counter for data-memory accesses; tc is high while the count sits at TIMEOUT_CYC-1.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable)
            count_d = count_q + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: EX/MEM register, LW/SW over a req/ack data port with wait states, MEM/WB register
// and the MEM-stage forwarding value.
module mem_stage_lsu
    import mips_pkg::*;
#(
    parameter int DW          = mips_pkg::DW,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_mem_rd,
    input  logic          ex_mem_wr,
    input  logic          ex_reg_wr,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic [4:0]    ex_dest_reg,
    output logic          stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          wb_valid,
    output logic          wb_reg_wr,
    output logic [4:0]    wb_dest_reg,
    output logic [DW-1:0] wb_data,
    output logic          mem_fwd_valid,
    output logic [4:0]    mem_fwd_reg,
    output logic [DW-1:0] mem_fwd_data,
    output logic          align_err,
    output logic          bus_err
);

    logic          exm_valid_q, exm_mem_rd_q, exm_mem_wr_q, exm_reg_wr_q;
    logic          exm_valid_d, exm_mem_rd_d, exm_mem_wr_d, exm_reg_wr_d;
    logic [DW-1:0] exm_alu_q, exm_alu_d, exm_store_q, exm_store_d;
    logic [4:0]    exm_dest_q, exm_dest_d;

    logic          wb_valid_q, wb_valid_d, wb_reg_wr_q, wb_reg_wr_d;
    logic [4:0]    wb_dest_q, wb_dest_d;
    logic [DW-1:0] wb_data_q, wb_data_d;

    lsu_state_t    state_q, state_d;
    logic          align_err_q, align_err_d, bus_err_q, bus_err_d;

    logic          mem_op, misaligned, done, tc;

    assign mem_op     = exm_valid_q & (exm_mem_rd_q | exm_mem_wr_q);
    assign misaligned = |(exm_alu_q[1:0] & ALIGN_MASK);

    // The counter runs only while the next state is ACCESS, so it is 0 in every IDLE cycle.
    mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_d != ACCESS),
        .enable (state_d == ACCESS),
        .tc     (tc)
    );

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        align_err_d = align_err_q;
        bus_err_d   = bus_err_q;
        dmem_req    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        align_err_d = 1'b1;
                        state_d     = ERROR;
                    end else begin
                        dmem_req = 1'b1;
                        if (!dmem_ack) begin
                            if (tc) begin
                                bus_err_d = 1'b1;
                                state_d   = ERROR;
                            end else begin
                                state_d = ACCESS;
                            end
                        end
                    end
                end
            end
            ACCESS: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_d = IDLE;
                end else if (tc) begin
                    bus_err_d = 1'b1;
                    state_d   = ERROR;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    assign done  = dmem_req & dmem_ack;
    assign stall = (state_q == ERROR) | (mem_op & ~done);

    always_comb begin
        exm_valid_d  = exm_valid_q;
        exm_mem_rd_d = exm_mem_rd_q;
        exm_mem_wr_d = exm_mem_wr_q;
        exm_reg_wr_d = exm_reg_wr_q;
        exm_alu_d    = exm_alu_q;
        exm_store_d  = exm_store_q;
        exm_dest_d   = exm_dest_q;
        if (!stall) begin
            exm_valid_d  = ex_valid;
            exm_mem_rd_d = ex_mem_rd;
            exm_mem_wr_d = ex_mem_wr;
            exm_reg_wr_d = ex_reg_wr;
            exm_alu_d    = ex_alu_result;
            exm_store_d  = ex_store_data;
            exm_dest_d   = ex_dest_reg;
        end
    end

    // A stalled cycle sends a bubble downstream but keeps the last dest/data visible.
    always_comb begin
        wb_valid_d  = 1'b0;
        wb_reg_wr_d = 1'b0;
        wb_dest_d   = wb_dest_q;
        wb_data_d   = wb_data_q;
        if (!stall) begin
            wb_valid_d  = exm_valid_q;
            wb_reg_wr_d = exm_valid_q & exm_reg_wr_q;
            wb_dest_d   = exm_dest_q;
            wb_data_d   = exm_mem_rd_q ? dmem_rdata : exm_alu_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            align_err_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            exm_valid_q  <= 1'b0;
            exm_mem_rd_q <= 1'b0;
            exm_mem_wr_q <= 1'b0;
            exm_reg_wr_q <= 1'b0;
            exm_alu_q    <= '0;
            exm_store_q  <= '0;
            exm_dest_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_reg_wr_q  <= 1'b0;
            wb_dest_q    <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            align_err_q  <= align_err_d;
            bus_err_q    <= bus_err_d;
            exm_valid_q  <= exm_valid_d;
            exm_mem_rd_q <= exm_mem_rd_d;
            exm_mem_wr_q <= exm_mem_wr_d;
            exm_reg_wr_q <= exm_reg_wr_d;
            exm_alu_q    <= exm_alu_d;
            exm_store_q  <= exm_store_d;
            exm_dest_q   <= exm_dest_d;
            wb_valid_q   <= wb_valid_d;
            wb_reg_wr_q  <= wb_reg_wr_d;
            wb_dest_q    <= wb_dest_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // mem_rd with mem_wr set is a load, so the write strobe needs mem_rd clear.
    assign dmem_we    = dmem_req & exm_mem_wr_q & ~exm_mem_rd_q;
    assign dmem_addr  = {exm_alu_q[DW-1:2], 2'b00};
    assign dmem_wdata = exm_store_q;

    assign wb_valid    = wb_valid_q;
    assign wb_reg_wr   = wb_reg_wr_q;
    assign wb_dest_reg = wb_dest_q;
    assign wb_data     = wb_data_q;

    assign mem_fwd_valid = exm_valid_q & exm_reg_wr_q & ~exm_mem_rd_q & (exm_dest_q != REG_ZERO);
    assign mem_fwd_reg   = exm_dest_q;
    assign mem_fwd_data  = exm_alu_q;

    assign align_err = align_err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus a randomized program checked
// against an in-order architectural model of loads, stores and write-backs.
module tb_mem_stage_lsu;

    localparam int DW = 32;
    localparam int TO = 4;
    localparam int N  = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr;
    logic [DW-1:0] ex_alu_result, ex_store_data;
    logic [4:0]    ex_dest_reg;
    logic          stall, dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          wb_valid, wb_reg_wr, mem_fwd_valid, align_err, bus_err;
    logic [4:0]    wb_dest_reg, mem_fwd_reg;
    logic [DW-1:0] wb_data, mem_fwd_data;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_dest_reg(wb_dest_reg), .wb_data(wb_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
        .align_err(align_err), .bus_err(bus_err)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] dmem    [64];
    logic [31:0] ref_mem [64];
    bit          resp_tied, resp_rand;
    int          resp_delay, resp_wait;

    typedef struct {
        logic        v, rd, wr, rw;
        logic [31:0] alu, sd;
        logic [4:0]  dst;
    } ins_t;

    ins_t        prog [N];
    logic [37:0] exp_q [$];

    task automatic drive(input logic v, rd, wr, rw, input logic [31:0] alu, sd, input logic [4:0] dst);
        ex_valid = v; ex_mem_rd = rd; ex_mem_wr = wr; ex_reg_wr = rw;
        ex_alu_result = alu; ex_store_data = sd; ex_dest_reg = dst;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Memory responder: tied ack, or ack after resp_delay wait cycles of a held request.
    task automatic respond();
        dmem_rdata = dmem[dmem_addr[7:2]];
        if (resp_tied) begin
            dmem_ack = 1'b1;
        end else if (dmem_req) begin
            if (resp_wait == 0 && resp_rand) resp_delay = int'($urandom_range(0, 2));
            dmem_ack  = (resp_wait >= resp_delay);
            resp_wait = dmem_ack ? 0 : resp_wait + 1;
        end else begin
            dmem_ack  = 1'b0;
            resp_wait = 0;
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        respond();
        #1;
    endtask

    task automatic end_cycle();
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:2]] = dmem_wdata;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bubble(); dmem_ack = 1'b0; resp_wait = 0; resp_tied = 1'b0; resp_rand = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", dmem_req); end
        checks++; if ({wb_valid, wb_reg_wr, wb_dest_reg, wb_data} !== 39'h0) begin
            failures++; $display("FAIL reset_wb got=%0b/%0b/%0d/%h exp=0", wb_valid, wb_reg_wr, wb_dest_reg, wb_data); end
        checks++; if ({mem_fwd_valid, align_err, bus_err, dmem_we, dmem_addr, dmem_wdata} !== 68'h0) begin
            failures++; $display("FAIL reset_misc got fwd=%0b al=%0b bus=%0b we=%0b addr=%h exp=0",
                                 mem_fwd_valid, align_err, bus_err, dmem_we, dmem_addr); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        resp_tied = 1'b1;
        dmem[16] = 32'hDEADBEEF;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd8);
        @(posedge clk);
        begin_cycle(); bubble();
        checks++; if ({stall, dmem_req, dmem_we} !== 3'b010) begin
            failures++; $display("FAIL zw_req got stall=%0b req=%0b we=%0b exp 0/1/0", stall, dmem_req, dmem_we); end
        checks++; if (dmem_addr !== 32'h40) begin failures++; $display("FAIL zw_addr got=%h exp=40", dmem_addr); end
        end_cycle();
        begin_cycle();
        checks++; if ({wb_valid, wb_reg_wr, wb_dest_reg, wb_data} !== {1'b1, 1'b1, 5'd8, 32'hDEADBEEF}) begin
            failures++; $display("FAIL zw_wb got=%0b/%0b/%0d/%h exp=1/1/8/deadbeef", wb_valid, wb_reg_wr, wb_dest_reg, wb_data); end
        end_cycle();
    endtask

    task automatic test_wait_states();
        int stalls = 0;
        do_reset();
        resp_delay = 3;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h1234, 5'd0);
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            begin_cycle(); bubble();
            if (stall) stalls++;
            if (c < 3) begin
                checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h80, 32'h1234}) begin
                    failures++; $display("FAIL ws_stable c=%0d got req=%0b we=%0b addr=%h wd=%h exp 1/1/80/1234",
                                         c, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
            end
            if (c > 0) begin
                checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL ws_bubble c=%0d got=%0b exp=0", c, wb_valid); end
            end
            end_cycle();
        end
        checks++; if (stalls != 3) begin failures++; $display("FAIL ws_stall_count got=%0d exp=3", stalls); end
        begin_cycle();
        checks++; if ({wb_valid, wb_reg_wr, stall, bus_err} !== 4'b1000) begin
            failures++; $display("FAIL ws_done got v=%0b rw=%0b stall=%0b bus=%0b exp 1/0/0/0", wb_valid, wb_reg_wr, stall, bus_err); end
        checks++; if (dmem[32] !== 32'h1234) begin failures++; $display("FAIL ws_mem got=%h exp=1234", dmem[32]); end
        end_cycle();
    endtask

    task automatic test_forwarding();
        do_reset();
        resp_tied = 1'b1;
        dmem[17] = 32'hA5A5_0011;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd7, 32'h0, 5'd3);
        @(posedge clk);
        begin_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 5'd5);
        checks++; if ({mem_fwd_valid, mem_fwd_reg, mem_fwd_data} !== {1'b1, 5'd3, 32'd7}) begin
            failures++; $display("FAIL fwd_addi got=%0b/%0d/%0d exp=1/3/7", mem_fwd_valid, mem_fwd_reg, mem_fwd_data); end
        end_cycle();
        begin_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd9, 32'h0, 5'd0);
        checks++; if (mem_fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_lw got=%0b exp=0", mem_fwd_valid); end
        end_cycle();
        begin_cycle(); bubble();
        checks++; if (mem_fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_r0 got=%0b exp=0", mem_fwd_valid); end
        checks++; if ({wb_valid, wb_dest_reg, wb_data} !== {1'b1, 5'd5, 32'hA5A5_0011}) begin
            failures++; $display("FAIL fwd_lw_wb got=%0b/%0d/%h exp=1/5/a5a50011", wb_valid, wb_dest_reg, wb_data); end
        end_cycle();
    endtask

    task automatic test_misaligned();
        int reqs = 0, unstalled = 0;
        do_reset();
        resp_tied = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h42, 32'h0, 5'd6);
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            begin_cycle(); bubble();
            if (dmem_req) reqs++;
            if (!stall) unstalled++;
            end_cycle();
        end
        begin_cycle();
        checks++; if (reqs != 0) begin failures++; $display("FAIL mis_req got=%0d exp=0", reqs); end
        checks++; if (unstalled != 0) begin failures++; $display("FAIL mis_stall got_unstalled=%0d exp=0", unstalled); end
        checks++; if ({align_err, bus_err, wb_valid} !== 3'b100) begin
            failures++; $display("FAIL mis_flags got al=%0b bus=%0b wbv=%0b exp 1/0/0", align_err, bus_err, wb_valid); end
        end_cycle();
    endtask

    task automatic test_timeout();
        int reqs = 0;
        do_reset();
        resp_delay = 1000;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h48, 32'h0, 5'd7);
        @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            begin_cycle(); bubble();
            if (dmem_req) reqs++;
            end_cycle();
        end
        begin_cycle();
        checks++; if (reqs != TO) begin failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", reqs, TO); end
        checks++; if ({bus_err, align_err, stall, wb_valid} !== 4'b1010) begin
            failures++; $display("FAIL to_flags got bus=%0b al=%0b stall=%0b wbv=%0b exp 1/0/1/0", bus_err, align_err, stall, wb_valid); end
        end_cycle();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        resp_delay = 1000;
        dmem[16] = 32'h0BAD_F00D;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h4C, 32'h0, 5'd4);
        @(posedge clk);
        begin_cycle(); bubble();
        checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rma_req_before got=%0b exp=1", dmem_req); end
        end_cycle();
        begin_cycle(); rst = 1'b1; end_cycle();
        begin_cycle();
        checks++; if ({dmem_req, stall, wb_valid} !== 3'b000) begin
            failures++; $display("FAIL rma_after got req=%0b stall=%0b wbv=%0b exp 0/0/0", dmem_req, stall, wb_valid); end
        rst = 1'b0;
        dmem_ack = 1'b1;
        end_cycle();
        begin_cycle();
        checks++; if ({dmem_req, stall, wb_valid} !== 3'b000) begin
            failures++; $display("FAIL rma_late_ack got req=%0b stall=%0b wbv=%0b exp 0/0/0", dmem_req, stall, wb_valid); end
        resp_tied = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd9);
        end_cycle();
        begin_cycle(); bubble(); end_cycle();
        begin_cycle();
        checks++; if ({wb_valid, wb_reg_wr, wb_dest_reg, wb_data} !== {1'b1, 1'b1, 5'd9, 32'h0BAD_F00D}) begin
            failures++; $display("FAIL rma_next_lw got=%0b/%0b/%0d/%h exp=1/1/9/0badf00d", wb_valid, wb_reg_wr, wb_dest_reg, wb_data); end
        end_cycle();
    endtask

    // Random program in program order: loads read and stores update the architectural memory.
    task automatic test_random();
        int idx = 0, cyc = 0, bad_words = 0;
        logic [37:0] exp_wb;
        do_reset();
        resp_rand = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dmem[i] = $urandom; ref_mem[i] = dmem[i];
        end
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            int kind = int'($urandom_range(0, 4));
            prog[i].v   = (kind != 4);
            prog[i].rd  = (kind == 1) || (kind == 3);
            prog[i].wr  = (kind == 2) || (kind == 3);
            prog[i].rw  = (kind != 2);
            prog[i].alu = (kind == 0 || kind == 4) ? $urandom : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            prog[i].sd  = $urandom;
            prog[i].dst = 5'($urandom_range(0, 31));
            if (prog[i].v) begin
                exp_q.push_back({prog[i].rw, prog[i].dst,
                                 prog[i].rd ? ref_mem[prog[i].alu[7:2]] : prog[i].alu});
                if (prog[i].wr && !prog[i].rd) ref_mem[prog[i].alu[7:2]] = prog[i].sd;
            end
        end
        while ((idx < N || exp_q.size() != 0) && cyc < 3000) begin
            begin_cycle();
            if (wb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_extra_wb got dest=%0d data=%h exp=none", wb_dest_reg, wb_data);
                end else begin
                    exp_wb = exp_q.pop_front();
                    if ({wb_reg_wr, wb_dest_reg, wb_data} !== exp_wb) begin
                        failures++; $display("FAIL rnd_wb got=%0b/%0d/%h exp=%0b/%0d/%h", wb_reg_wr, wb_dest_reg, wb_data,
                                             exp_wb[37], exp_wb[36:32], exp_wb[31:0]);
                    end
                end
            end
            if (idx < N) drive(prog[idx].v, prog[idx].rd, prog[idx].wr, prog[idx].rw, prog[idx].alu, prog[idx].sd, prog[idx].dst);
            else bubble();
            if (!stall && idx < N) idx++;
            end_cycle();
            cyc++;
        end
        checks++; if (cyc >= 3000 || exp_q.size() != 0) begin
            failures++; $display("FAIL rnd_timeout got issued=%0d pending=%0d exp all retired", idx, exp_q.size()); end
        for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) bad_words++;
        checks++; if (bad_words != 0) begin failures++; $display("FAIL rnd_mem got bad_words=%0d exp=0", bad_words); end
        checks++; if ({align_err, bus_err} !== 2'b00) begin
            failures++; $display("FAIL rnd_err got al=%0b bus=%0b exp 0/0", align_err, bus_err); end
    endtask

    initial begin
        rst = 1'b1; bubble(); dmem_ack = 1'b0; dmem_rdata = '0;
        resp_tied = 1'b0; resp_rand = 1'b0; resp_delay = 0; resp_wait = 0;
        for (int i = 0; i < 64; i++) dmem[i] = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_forwarding();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
